// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth sequential multiplier:
// controller state encoding and the digit-count rule.
package booth_pkg;

    // Controller states: wait for operands, retire digits, present product.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of one Booth triplet (b[2i+1], b[2i], b[2i-1]).
    localparam int TRIPLET_W = 3;

    // Radix-4 digits needed for a W-bit operand extended to W+2 bits.
    // The same count is used for signed and unsigned, so latency is fixed.
    function automatic int digit_count(input int w);
        return w / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_digit_enc.sv
// Radix-4 Booth recoder: maps one multiplier triplet to a digit in
// {-2,-1,0,+1,+2}, expressed as magnitude selects (one/two) and a sign (neg).
module booth_digit_enc
    import booth_pkg::*;
(
    input  logic [TRIPLET_W-1:0] trip,
    output logic                 one,
    output logic                 two,
    output logic                 neg
);

    // Pure decode of the triplet; every output gets a value on every path.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves an output
        // unassigned, which would otherwise infer a latch.
        one = 1'b0;
        two = 1'b0;
        neg = 1'b0;
        unique case (trip)
            3'b000: ;                             //  0
            3'b001: one = 1'b1;                   // +1
            3'b010: one = 1'b1;                   // +1
            3'b011: two = 1'b1;                   // +2
            3'b100: begin two = 1'b1; neg = 1'b1; end // -2
            3'b101: begin one = 1'b1; neg = 1'b1; end // -1
            3'b110: begin one = 1'b1; neg = 1'b1; end // -1
            3'b111: ;                             //  0 (no negative zero)
            default: ;
        endcase
    end

endmodule

// File: rtl/booth_seq_mult.sv
// Iterative radix-4 Booth multiplier, one digit retired per clock.
// Handshaked input (in_valid/in_ready) and output (out_valid/out_ready).
// Result is the exact 2W-bit product for signed or unsigned operands.
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    input  logic           in_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_p
);

    localparam int D  = digit_count(W);
    localparam int CW = $clog2(D + 1);
    localparam int PW = 2 * W;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(D - 1);

    state_t state, state_nx;

    // Multiplier holds {b_ext, implicit 0}; the low triplet is always the
    // current digit. The multiplicand is pre-extended to the product width
    // and shifted left by two per digit, which supplies the 2i weighting.
    logic [W+2:0]    mult_q;
    logic [PW-1:0]   mcand_q;
    logic [PW-1:0]   acc_q;
    logic [PW-1:0]   prod_q;
    logic [CW-1:0]   cnt_q;

    logic            dig_one, dig_two, dig_neg;
    logic [PW-1:0]   pp_mag;
    logic [PW-1:0]   pp;
    logic            accept, retire, last_digit;

    logic            ext_a, ext_b;
    logic [W+1:0]    a_ext;
    logic [W+1:0]    b_ext;

    // Operand extension: sign fill in signed mode, zero fill otherwise.
    assign ext_a = in_signed & in_a[W-1];
    assign ext_b = in_signed & in_b[W-1];
    assign a_ext = {{2{ext_a}}, in_a};
    assign b_ext = {{2{ext_b}}, in_b};

    booth_digit_enc u_enc (
        .trip (mult_q[TRIPLET_W-1:0]),
        .one  (dig_one),
        .two  (dig_two),
        .neg  (dig_neg)
    );

    // Partial product for the current digit, already at weight 4^i.
    always_comb begin
        pp_mag = '0;
        if (dig_two)
            pp_mag = mcand_q << 1;
        else if (dig_one)
            pp_mag = mcand_q;
        pp = dig_neg ? (~pp_mag + PW'(1)) : pp_mag;
    end

    assign accept     = (state == IDLE) && in_valid;
    assign retire     = (state == RUN);
    assign last_digit = retire && (cnt_q == LAST_DIGIT);

    // State register; reset wins over any handshake on the same edge.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nx = RUN;
            end
            RUN: begin
                if (cnt_q == LAST_DIGIT)
                    state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: load on accept, accumulate one digit per RUN cycle, and
    // latch the finished product so out_p only ever shows complete results.
    always_ff @(posedge clk) begin
        if (rst) begin
            mult_q  <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
        end else if (accept) begin
            mult_q  <= {b_ext, 1'b0};
            mcand_q <= {{(PW-W-2){ext_a}}, a_ext};
            acc_q   <= '0;
            cnt_q   <= '0;
        end else if (retire) begin
            mult_q  <= mult_q >> 2;
            mcand_q <= mcand_q << 2;
            acc_q   <= acc_q + pp;
            cnt_q   <= cnt_q + CW'(1);
            if (last_digit)
                prod_q <= acc_q + pp;
        end
    end

    assign out_p = prod_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult at W=16 and W=8: directed corner
// cases, backpressure, mid-run reset, and a random regression against a
// plain-arithmetic reference product.
module tb_booth_seq_mult;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // W=16 instance
    logic        v16, r16, s16, ov16, or16;
    logic [15:0] a16, b16;
    logic [31:0] p16;

    // W=8 instance
    logic        v8, r8, s8, ov8, or8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    int n_tests = 0;
    int n_fail  = 0;

    booth_seq_mult #(.W(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16), .in_a(a16), .in_b(b16),
        .in_signed(s16), .out_valid(ov16), .out_ready(or16), .out_p(p16)
    );

    booth_seq_mult #(.W(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .in_a(a8), .in_b(b8),
        .in_signed(s8), .out_valid(ov8), .out_ready(or8), .out_p(p8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: extend each operand to 64 bits per mode, multiply, keep 2w bits.
    function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                            input int w, input bit s);
        logic [63:0] lo_mask;
        logic [63:0] xa, xb, prod;
        lo_mask = (64'd1 << w) - 64'd1;
        xa = a & lo_mask;
        xb = b & lo_mask;
        if (s && xa[w-1]) xa = xa | ~lo_mask;
        if (s && xb[w-1]) xb = xb | ~lo_mask;
        prod = xa * xb;
        return prod & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // One full W=16 transaction with latency and product checks.
    task automatic txn16(input logic [15:0] a, input logic [15:0] b, input bit s,
                         input logic [31:0] exp, input string tag);
        int lat;
        lat = 0;
        while (!r16 && lat < 50) begin @(posedge clk); #1; lat++; end
        check({tag, "_in_ready"}, 64'(r16), 64'd1);
        a16 = a; b16 = b; s16 = s; v16 = 1'b1;
        @(posedge clk); #1;
        // Scramble operands and mode after accept: must not matter.
        v16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); s16 = ~s;
        lat = 0;
        while (!ov16 && lat < 50) begin @(posedge clk); #1; lat++; end
        check({tag, "_lat"}, 64'(lat), 64'd9);
        check({tag, "_p"}, 64'(p16), 64'(exp));
        or16 = 1'b1;
        @(posedge clk); #1;
        or16 = 1'b0;
    endtask

    // One full W=8 transaction with latency and product checks.
    task automatic txn8(input logic [7:0] a, input logic [7:0] b, input bit s,
                        input logic [15:0] exp, input string tag);
        int lat;
        lat = 0;
        while (!r8 && lat < 50) begin @(posedge clk); #1; lat++; end
        check({tag, "_in_ready"}, 64'(r8), 64'd1);
        a8 = a; b8 = b; s8 = s; v8 = 1'b1;
        @(posedge clk); #1;
        v8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); s8 = ~s;
        lat = 0;
        while (!ov8 && lat < 50) begin @(posedge clk); #1; lat++; end
        check({tag, "_lat"}, 64'(lat), 64'd5);
        check({tag, "_p"}, 64'(p8), 64'(exp));
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
    endtask

    initial begin
        int lat;
        bit seen;
        logic [31:0] exp_bp;

        rst = 1'b1;
        v16 = 0; a16 = 0; b16 = 0; s16 = 0; or16 = 0;
        v8  = 0; a8  = 0; b8  = 0; s8  = 0; or8  = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_in_ready16", 64'(r16), 64'd1);
        check("rst_out_valid16", 64'(ov16), 64'd0);
        check("rst_out_p16", 64'(p16), 64'd0);
        check("rst_in_ready8", 64'(r8), 64'd1);
        check("rst_out_p8", 64'(p8), 64'd0);

        // Directed corners.
        txn16(16'h8000, 16'h8000, 1'b1, 32'h4000_0000, "min_x_min_s16");
        txn16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, "ffff_u16");
        txn16(16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001, "ffff_s16");
        txn8(8'h80, 8'h7F, 1'b1, 16'hC080, "80x7f_s8");
        txn8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "ffff_u8");

        // Backpressure: product held, no new accept while DONE.
        exp_bp = 32'(ref_mul(64'h1234, 64'h5678, 16, 1'b0));
        a16 = 16'h1234; b16 = 16'h5678; s16 = 1'b0; v16 = 1'b1;
        @(posedge clk); #1 v16 = 1'b0;
        lat = 0;
        while (!ov16 && lat < 50) begin @(posedge clk); #1; lat++; end
        check("bp_first_p", 64'(p16), 64'(exp_bp));
        for (int i = 0; i < 5; i++) begin
            v16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom);
            @(posedge clk); #1;
            v16 = 1'b0;
            check("bp_p_stable", 64'(p16), 64'(exp_bp));
            check("bp_in_ready", 64'(r16), 64'd0);
            check("bp_out_valid", 64'(ov16), 64'd1);
        end
        or16 = 1'b1;
        @(posedge clk); #1 or16 = 1'b0;
        check("bp_release_idle", 64'(r16), 64'd1);
        check("bp_release_ov", 64'(ov16), 64'd0);
        txn16(16'h00FF, 16'hFF01, 1'b1, 32'(ref_mul(64'h00FF, 64'hFF01, 16, 1'b1)), "bp_next");

        // Reset on edge 3 after accept aborts the transaction.
        a16 = 16'h7FFF; b16 = 16'h7FFF; s16 = 1'b1; v16 = 1'b1;
        @(posedge clk); #1 v16 = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("midrst_in_ready", 64'(r16), 64'd1);
        check("midrst_out_valid", 64'(ov16), 64'd0);
        check("midrst_out_p", 64'(p16), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (ov16 || p16 != 32'd0) seen = 1'b1;
        end
        check("midrst_no_partial", 64'(seen), 64'd0);
        txn16(16'd3, 16'hFFFB, 1'b1, 32'hFFFF_FFF1, "3x_m5_s16");

        // Reset beats an accept on the same edge.
        v16 = 1'b1; a16 = 16'd5; b16 = 16'd7; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; v16 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (ov16 || !r16) seen = 1'b1;
        end
        check("rst_over_accept", 64'(seen), 64'd0);

        // Random regression, both widths concurrently.
        fork
            begin
                for (int i = 0; i < 5000; i++) begin
                    logic [15:0] ra, rb;
                    bit rs;
                    ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom_range(0, 1));
                    txn16(ra, rb, rs, 32'(ref_mul(64'(ra), 64'(rb), 16, rs)), "rnd16");
                end
            end
            begin
                for (int i = 0; i < 5000; i++) begin
                    logic [7:0] ra, rb;
                    bit rs;
                    ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom_range(0, 1));
                    txn8(ra, rb, rs, 16'(ref_mul(64'(ra), 64'(rb), 8, rs)), "rnd8");
                end
            end
        join

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_seq_mult.md
BOOTH_SEQ_MULT -- requirements
Module: booth_seq_mult

Interface
REQ-001 SHALL have parameter W, default 16, giving operand width; W even and at least 4.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1, the reset: one clock, reset synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, operands present.
REQ-005 SHALL have port in_ready, output, 1, block can accept operands.
REQ-006 SHALL have port in_a, input, W, multiplicand.
REQ-007 SHALL have port in_b, input, W, multiplier.
REQ-008 SHALL have port in_signed, input, 1: 1 = two's-complement operands, 0 = unsigned.
REQ-009 SHALL have port out_valid, output, 1, product present.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts product.
REQ-011 SHALL have port out_p, output, 2W, product.

Function
REQ-012 SHALL implement an iterative radix-4 Booth multiplier that retires one Booth digit per cycle.
REQ-013 SHALL use the state machine IDLE -> RUN -> DONE -> IDLE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 Accept: on an edge in IDLE with in_valid=1, SHALL capture in_a, in_b and in_signed, clear the accumulator, zero the digit counter, and enter RUN.
REQ-016 Extension: in_b SHALL be extended to W+2 bits with an implicit 0 below bit 0; the top bits are the sign bit when in_signed=1 and 0 otherwise.
REQ-016a in_a SHALL be extended to W+2 bits by the same rule.
REQ-017 Digit count SHALL be D = W/2+1 in both modes, giving fixed latency; the extra digit is always 0 in signed mode.
REQ-018 Digit i, with i from 0 to D-1, SHALL decode triplet b_ext[2i+1:2i-1] into one, two and neg.
REQ-018a The accumulator SHALL add a_ext, 2*a_ext, -a_ext, -2*a_ext or 0 for digit i, shifted left by 2i.
REQ-019 Accumulator arithmetic SHALL be modulo 2^(2W); out_p is the low 2W bits and is the exact product in both modes.
REQ-020 Latency: with the accept edge as edge 0, digit i SHALL be retired on edge i+1.
REQ-020a DONE SHALL be entered on edge D, so out_valid is first high D cycles after accept (9 cycles for W=16).
REQ-021 In DONE, out_p SHALL be held stable until out_valid and out_ready are both 1 on an edge; the block then returns to IDLE.
REQ-022 in_valid SHALL be ignored outside IDLE.
REQ-022a Operand inputs SHALL be don't-care after the accept edge.
REQ-023 Back-to-back operation: there SHALL be at least one IDLE cycle between transactions; there is no overlap.
REQ-024 Changing in_signed outside the accept edge SHALL have no effect on the transaction in flight.

Reset
REQ-025 rst=1 on an edge SHALL force IDLE, in_ready=1, out_valid=0, out_p=0, and clear the accumulator and counter, from any state.
REQ-026 rst SHALL take priority over an accept or out handshake on the same edge.
REQ-026a After reset, no partial product from the aborted transaction SHALL ever appear on out_p.

Structure
REQ-027 The state encoding (IDLE, RUN, DONE) and a digit-count function of W SHALL live in shared package booth_pkg.
REQ-028 The triplet-to-(one,two,neg) recoder SHALL be a separate combinational sub-module named booth_digit_enc, instantiated once.
REQ-029 Target size: 120-400 lines of RTL.

Verification
REQ-030 W=16 signed: in_a=0x8000, in_b=0x8000 -> out_p=0x40000000, with out_valid rising 9 cycles after accept.
REQ-031 W=16 unsigned: in_a=0xFFFF, in_b=0xFFFF -> 0xFFFE0001; signed with the same operands -> 0x00000001.
REQ-032 W=8: signed 0x80 x 0x7F -> 0xC080; unsigned 0xFF x 0xFF -> 0xFE01; both with latency 5.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_p stable and in_ready=0; in_valid pulses during this time are not accepted.
REQ-033a On out_ready=1 the block returns to IDLE, then accepts the next operands.
REQ-034 Reset mid-RUN: assert rst on edge 3 after accept -> next cycle IDLE, out_valid=0, out_p=0.
REQ-034a After that reset, a new transaction 3 x -5 signed -> 0xFFFFFFF1.
REQ-035 Random regression: at least 10k random operand and mode pairs at W=16 and W=8, checked against a reference model; every result SHALL match.
